// File: rtl/pe_line_buffer_if.sv
// Write and read port bundle between the renderer / PE sequencer and the scanline buffer.
// Write handshake: a word transfers on a clock edge where wr_valid and wr_ready are both high.
interface pe_line_buffer_if #(
    parameter int DW = 16
);
    logic          wr_valid;
    logic          wr_ready;
    logic [7:0]    wr_col;
    logic          wr_sel;
    logic [DW-1:0] wr_data;
    logic          wr_line_done;
    logic [7:0]    col;
    logic          send_address_1;
    logic          send_address_2;
    logic [DW-1:0] data_1;
    logic [DW-1:0] data_2;
    logic          rd_line_done;

    modport master (
        output wr_valid, wr_col, wr_sel, wr_data, wr_line_done,
        output col, send_address_1, send_address_2, rd_line_done,
        input  wr_ready, data_1, data_2
    );

    modport slave (
        input  wr_valid, wr_col, wr_sel, wr_data, wr_line_done,
        input  col, send_address_1, send_address_2, rd_line_done,
        output wr_ready, data_1, data_2
    );
endinterface

// File: rtl/pe_line_buffer.sv
// Double-buffered scanline store: renderer fills the back bank, PE sequencer reads the front bank
// through two one-cycle-latency strobed ports; banks swap once a line is done and the front is free.
module pe_line_buffer #(
    parameter int COLS = 160,
    parameter int DW   = 16
) (
    input  logic             clock,
    input  logic             reset,
    pe_line_buffer_if.slave  bus,
    output logic             line_ready,
    output logic             underrun,
    output logic             wr_err,
    input  logic             clear_flags,
    output logic             wr_state_dbg
);
    localparam int         AW     = (COLS > 1) ? $clog2(COLS) : 1;
    localparam logic [8:0] COLS_W = 9'(COLS);

    typedef enum logic {
        FILL      = 1'b0,
        WAIT_SWAP = 1'b1
    } wr_state_t;

    wr_state_t state, state_next;

    logic          front;
    logic          back;
    logic          wr_fire;
    logic          wr_in_range;
    logic          rd_in_range;
    logic          line_pending;
    logic          front_free;
    logic          swap;
    logic          line_ready_next;
    logic          any_strobe;
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] rd_idx;

    // Contents are deliberately not reset; line_ready gates every read.
    logic [DW-1:0] word1_mem [2][COLS];
    logic [DW-1:0] word2_mem [2][COLS];

    assign back         = ~front;
    assign wr_fire      = bus.wr_valid && bus.wr_ready;
    assign wr_in_range  = {1'b0, bus.wr_col} < COLS_W;
    assign rd_in_range  = {1'b0, bus.col} < COLS_W;
    assign wr_idx       = bus.wr_col[AW-1:0];
    assign rd_idx       = bus.col[AW-1:0];
    assign any_strobe   = bus.send_address_1 || bus.send_address_2;
    assign wr_state_dbg = state;

    // A line counts as pending in the very cycle wr_line_done arrives, so an idle
    // front lets the writer turn around without a stall cycle.
    assign line_pending = (state == WAIT_SWAP) || (state == FILL && bus.wr_line_done);
    assign front_free   = !line_ready || bus.rd_line_done;
    assign swap         = line_pending && front_free;

    always_comb begin
        state_next   = state;
        bus.wr_ready = 1'b0;
        case (state)
            FILL: begin
                bus.wr_ready = 1'b1;
                if (bus.wr_line_done && !swap) state_next = WAIT_SWAP;
            end
            WAIT_SWAP: begin
                if (swap) state_next = FILL;
            end
            default: state_next = FILL;
        endcase
    end

    always_comb begin
        line_ready_next = line_ready;
        if (swap)                   line_ready_next = 1'b1;
        else if (bus.rd_line_done)  line_ready_next = 1'b0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= FILL;
            front      <= 1'b0;
            line_ready <= 1'b0;
        end else begin
            state      <= state_next;
            line_ready <= line_ready_next;
            if (swap) front <= ~front;
        end
    end

    // Writes use the pre-swap back bank, so a write alongside wr_line_done lands in the finishing line.
    always_ff @(posedge clock) begin
        if (wr_fire && wr_in_range) begin
            if (bus.wr_sel) word2_mem[back][wr_idx] <= bus.wr_data;
            else            word1_mem[back][wr_idx] <= bus.wr_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bus.data_1 <= '0;
            bus.data_2 <= '0;
        end else begin
            if (bus.send_address_1) begin
                if (line_ready && rd_in_range) bus.data_1 <= word1_mem[front][rd_idx];
                else                           bus.data_1 <= '0;
            end
            if (bus.send_address_2) begin
                if (line_ready && rd_in_range) bus.data_2 <= word2_mem[front][rd_idx];
                else                           bus.data_2 <= '0;
            end
        end
    end

    // Setting a flag takes priority over clearing it in the same cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            underrun <= 1'b0;
            wr_err   <= 1'b0;
        end else begin
            if (any_strobe && !line_ready) underrun <= 1'b1;
            else if (clear_flags)          underrun <= 1'b0;
            if (wr_fire && !wr_in_range)   wr_err <= 1'b1;
            else if (clear_flags)          wr_err <= 1'b0;
        end
    end
endmodule

// File: tb/tb_pe_line_buffer.sv
// Directed bench for pe_line_buffer: fill/swap/read sequences with hand-computed expectations.
module tb_pe_line_buffer;
    logic clock;
    logic reset;
    logic line_ready;
    logic underrun;
    logic wr_err;
    logic clear_flags;
    logic wr_state_dbg;

    int checks   = 0;
    int failures = 0;

    pe_line_buffer_if #(.DW(16)) bus ();

    pe_line_buffer #(.COLS(160), .DW(16)) dut (
        .clock        (clock),
        .reset        (reset),
        .bus          (bus),
        .line_ready   (line_ready),
        .underrun     (underrun),
        .wr_err       (wr_err),
        .clear_flags  (clear_flags),
        .wr_state_dbg (wr_state_dbg)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic write_word(input logic [7:0] c, input logic sel, input logic [15:0] d,
                              input logic done);
        bus.wr_valid     = 1'b1;
        bus.wr_col       = c;
        bus.wr_sel       = sel;
        bus.wr_data      = d;
        bus.wr_line_done = done;
        step();
        bus.wr_valid     = 1'b0;
        bus.wr_line_done = 1'b0;
    endtask

    task automatic write_line(input logic [15:0] b1, input logic [15:0] b2, input int ncols);
        for (int c = 0; c < ncols; c++) begin
            write_word(8'(c), 1'b0, b1 + 16'(c), 1'b0);
            write_word(8'(c), 1'b1, b2 + 16'(c), 1'b0);
        end
    endtask

    task automatic rd(input logic p1, input logic p2, input logic [7:0] c, input logic rdone);
        bus.col            = c;
        bus.send_address_1 = p1;
        bus.send_address_2 = p2;
        bus.rd_line_done   = rdone;
        step();
        bus.send_address_1 = 1'b0;
        bus.send_address_2 = 1'b0;
        bus.rd_line_done   = 1'b0;
    endtask

    task automatic pulse(input logic wld, input logic rld);
        bus.wr_line_done = wld;
        bus.rd_line_done = rld;
        step();
        bus.wr_line_done = 1'b0;
        bus.rd_line_done = 1'b0;
    endtask

    initial begin
        reset              = 1'b1;
        clear_flags        = 1'b0;
        bus.wr_valid       = 1'b0;
        bus.wr_col         = '0;
        bus.wr_sel         = 1'b0;
        bus.wr_data        = '0;
        bus.wr_line_done   = 1'b0;
        bus.col            = '0;
        bus.send_address_1 = 1'b0;
        bus.send_address_2 = 1'b0;
        bus.rd_line_done   = 1'b0;
        repeat (2) step();

        check("rst_line_ready", 32'(line_ready), 32'd0);
        check("rst_wr_ready", 32'(bus.wr_ready), 32'd1);
        check("rst_data_1", 32'(bus.data_1), 32'd0);
        check("rst_data_2", 32'(bus.data_2), 32'd0);
        check("rst_underrun", 32'(underrun), 32'd0);
        check("rst_wr_err", 32'(wr_err), 32'd0);
        reset = 1'b0;
        step();

        // Underrun right after reset, clear, then clear racing a new underrun
        rd(1'b1, 1'b0, 8'd5, 1'b0);
        check("ur_data_1", 32'(bus.data_1), 32'd0);
        check("ur_flag_set", 32'(underrun), 32'd1);
        clear_flags = 1'b1;
        step();
        check("ur_flag_clr", 32'(underrun), 32'd0);
        bus.send_address_1 = 1'b1;
        step();
        bus.send_address_1 = 1'b0;
        clear_flags = 1'b0;
        check("ur_set_wins", 32'(underrun), 32'd1);
        clear_flags = 1'b1;
        step();
        clear_flags = 1'b0;

        // Line A: word1[c] = c, word2[c] = 0x100 + c
        write_line(16'h0000, 16'h0100, 160);
        check("a_not_ready_before", 32'(line_ready), 32'd0);
        pulse(1'b1, 1'b0);
        check("a_line_ready", 32'(line_ready), 32'd1);
        check("a_wr_ready", 32'(bus.wr_ready), 32'd1);
        rd(1'b1, 1'b0, 8'd5, 1'b0);
        check("a_rd1_col5", 32'(bus.data_1), 32'h0005);
        rd(1'b0, 1'b1, 8'd159, 1'b0);
        check("a_rd2_col159", 32'(bus.data_2), 32'h019F);
        check("a_rd1_hold", 32'(bus.data_1), 32'h0005);
        rd(1'b1, 1'b1, 8'd10, 1'b0);
        check("a_both_1", 32'(bus.data_1), 32'h000A);
        check("a_both_2", 32'(bus.data_2), 32'h010A);
        check("a_no_underrun", 32'(underrun), 32'd0);

        // Range errors
        write_word(8'd160, 1'b0, 16'hDEAD, 1'b0);
        check("oor_wr_err", 32'(wr_err), 32'd1);
        rd(1'b1, 1'b1, 8'd200, 1'b0);
        check("oor_rd_1", 32'(bus.data_1), 32'd0);
        check("oor_rd_2", 32'(bus.data_2), 32'd0);
        clear_flags = 1'b1;
        step();
        clear_flags = 1'b0;
        check("oor_wr_err_clr", 32'(wr_err), 32'd0);

        // Backpressure: line B waits until the reader releases line A
        write_line(16'h0200, 16'h0300, 160);
        pulse(1'b1, 1'b0);
        check("bp_wr_ready_low", 32'(bus.wr_ready), 32'd0);
        check("bp_line_ready", 32'(line_ready), 32'd1);
        write_word(8'd0, 1'b0, 16'h0BAD, 1'b0);
        check("bp_still_low", 32'(bus.wr_ready), 32'd0);
        rd(1'b1, 1'b0, 8'd7, 1'b1);
        check("bp_swap_cycle_old", 32'(bus.data_1), 32'h0007);
        check("bp_line_ready_kept", 32'(line_ready), 32'd1);
        check("bp_wr_ready_back", 32'(bus.wr_ready), 32'd1);
        rd(1'b1, 1'b1, 8'd7, 1'b0);
        check("bp_new_line_1", 32'(bus.data_1), 32'h0207);
        check("bp_new_line_2", 32'(bus.data_2), 32'h0307);
        rd(1'b1, 1'b0, 8'd0, 1'b0);
        check("bp_rejected_wr", 32'(bus.data_1), 32'h0200);
        rd(1'b1, 1'b0, 8'd160, 1'b0);
        check("bp_no_alias", 32'(bus.data_1), 32'd0);

        // Line C, last write together with wr_line_done, swap together with rd_line_done
        write_line(16'h0400, 16'h0500, 9);
        write_word(8'd9, 1'b0, 16'h0409, 1'b0);
        check("c_pending_wait", 32'(bus.wr_ready), 32'd1);
        bus.rd_line_done = 1'b1;
        write_word(8'd9, 1'b1, 16'h0509, 1'b1);
        bus.rd_line_done = 1'b0;
        check("sim_line_ready", 32'(line_ready), 32'd1);
        check("sim_wr_ready", 32'(bus.wr_ready), 32'd1);
        rd(1'b1, 1'b1, 8'd9, 1'b0);
        check("c_rd1_col9", 32'(bus.data_1), 32'h0409);
        check("c_wr_with_done", 32'(bus.data_2), 32'h0509);
        rd(1'b1, 1'b0, 8'd3, 1'b0);
        check("c_rd1_col3", 32'(bus.data_1), 32'h0403);
        pulse(1'b0, 1'b1);
        check("rdone_drop", 32'(line_ready), 32'd0);
        check("rdone_wr_ready", 32'(bus.wr_ready), 32'd1);
        rd(1'b0, 1'b1, 8'd3, 1'b0);
        check("rdone_rd_zero", 32'(bus.data_2), 32'd0);
        check("rdone_underrun", 32'(underrun), 32'd1);
        check("rdone_rd1_hold", 32'(bus.data_1), 32'h0403);
        clear_flags = 1'b1;
        step();
        clear_flags = 1'b0;

        // Line D then reset in the middle of filling the next line
        write_line(16'h0600, 16'h0700, 4);
        pulse(1'b1, 1'b0);
        check("d_line_ready", 32'(line_ready), 32'd1);
        rd(1'b1, 1'b1, 8'd1, 1'b0);
        check("d_rd1", 32'(bus.data_1), 32'h0601);
        check("d_rd2", 32'(bus.data_2), 32'h0701);
        for (int c = 0; c < 80; c++) write_word(8'(c), 1'b0, 16'h0800 + 16'(c), 1'b0);
        @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        check("mr_line_ready", 32'(line_ready), 32'd0);
        check("mr_wr_ready", 32'(bus.wr_ready), 32'd1);
        check("mr_data_1", 32'(bus.data_1), 32'd0);
        check("mr_data_2", 32'(bus.data_2), 32'd0);
        step();
        reset = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
